// File: rtl/banco_registradores_mp_pkg.sv
// Shared MIPS register-file package.
// Holds the default data/address widths, the hardwired zero register
// address and the read-source priority encoding used by the bypass muxes.
package banco_registradores_mp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int ADDR_DEF  = 5;
  localparam int ZERO_ADDR = 0;

  // Read-source select. Priority: zero register, then write port 1
  // (memory), then write port 0 (ALU), then array contents.
  typedef enum logic [1:0] {
    SEL_ARRAY = 2'd0,
    SEL_WR0   = 2'd1,
    SEL_WR1   = 2'd2,
    SEL_ZERO  = 2'd3
  } rd_sel_e;

  function automatic rd_sel_e rd_sel(input logic zero_hit, input logic hit1,
                                     input logic hit0);
    if (zero_hit)  return SEL_ZERO;
    else if (hit1) return SEL_WR1;
    else if (hit0) return SEL_WR0;
    else           return SEL_ARRAY;
  endfunction

endpackage

// File: rtl/banco_registradores_mp_scoreboard.sv
// reg_scoreboard: per-register pending (reservation) vector.
// Ports:
//   clock, reset          - clock, async active-high reset
//   reserve, reserve_reg  - mark a register pending (load issued)
//   wr0_en/wr0_reg,
//   wr1_en/wr1_reg        - qualified write hits (zero-register writes removed)
//   read1, read2          - read addresses
//   busy1, busy2          - pending and not being completed this cycle
module reg_scoreboard
  import banco_registradores_mp_pkg::*;
#(
  parameter int ADDR     = ADDR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            reserve,
  input  logic [ADDR-1:0] reserve_reg,
  input  logic            wr0_en,
  input  logic [ADDR-1:0] wr0_reg,
  input  logic            wr1_en,
  input  logic [ADDR-1:0] wr1_reg,
  input  logic [ADDR-1:0] read1,
  input  logic [ADDR-1:0] read2,
  output logic            busy1,
  output logic            busy2
);

  localparam int DEPTH = 2 ** ADDR;

  logic [DEPTH-1:0] pending, set_v, clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (reserve && !(ZERO_REG && reserve_reg == ADDR'(ZERO_ADDR)))
      set_v[reserve_reg] = 1'b1;
    if (wr0_en) clr_v[wr0_reg] = 1'b1;
    if (wr1_en) clr_v[wr1_reg] = 1'b1;
  end

  // Set is applied after clear: a reserve in the same cycle as a write
  // means a newer producer exists, so the register stays pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_v) | set_v;
  end

  // A completing write bypasses its data, so busy drops the same cycle.
  assign busy1 = pending[read1] && !clr_v[read1];
  assign busy2 = pending[read2] && !clr_v[read2];

endmodule

// File: rtl/banco_registradores_mp.sv
// banco_registradores_mp: 2-write / 2-read register file with zero register,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
// Ports:
//   clock, reset                      - clock, async active-high reset
//   Read1/Read2 -> Data1/Data2        - combinational reads with bypass
//   Busy1/Busy2                       - read register has an outstanding reserve
//   RegWrite0/WriteReg0/WriteData0    - ALU write-back (lower priority)
//   RegWrite1/WriteReg1/WriteData1    - memory write-back (higher priority)
//   Reserve/ReserveReg                - mark register pending
module banco_registradores_mp
  import banco_registradores_mp_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR     = ADDR_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ADDR-1:0]  Read1,
  input  logic [ADDR-1:0]  Read2,
  output logic [WIDTH-1:0] Data1,
  output logic [WIDTH-1:0] Data2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic             RegWrite0,
  input  logic [ADDR-1:0]  WriteReg0,
  input  logic [WIDTH-1:0] WriteData0,
  input  logic             RegWrite1,
  input  logic [ADDR-1:0]  WriteReg1,
  input  logic [WIDTH-1:0] WriteData1,
  input  logic             Reserve,
  input  logic [ADDR-1:0]  ReserveReg
);

  localparam int DEPTH = 2 ** ADDR;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic    wr0_ok, wr1_ok;
  rd_sel_e sel1, sel2;

  // Writes to the hardwired zero register are dropped before they reach
  // the array, the bypass or the scoreboard.
  assign wr0_ok = RegWrite0 && !(ZERO_REG && WriteReg0 == ADDR'(ZERO_ADDR));
  assign wr1_ok = RegWrite1 && !(ZERO_REG && WriteReg1 == ADDR'(ZERO_ADDR));

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs <= '0;
    else begin
      if (wr0_ok) regs[WriteReg0] <= WriteData0;
      if (wr1_ok) regs[WriteReg1] <= WriteData1;
    end
  end

  assign sel1 = rd_sel(ZERO_REG && Read1 == ADDR'(ZERO_ADDR),
                       wr1_ok && WriteReg1 == Read1,
                       wr0_ok && WriteReg0 == Read1);
  assign sel2 = rd_sel(ZERO_REG && Read2 == ADDR'(ZERO_ADDR),
                       wr1_ok && WriteReg1 == Read2,
                       wr0_ok && WriteReg0 == Read2);

  always_comb begin
    Data1 = regs[Read1];
    unique case (sel1)
      SEL_ZERO: Data1 = '0;
      SEL_WR1:  Data1 = WriteData1;
      SEL_WR0:  Data1 = WriteData0;
      default:  Data1 = regs[Read1];
    endcase
  end

  always_comb begin
    Data2 = regs[Read2];
    unique case (sel2)
      SEL_ZERO: Data2 = '0;
      SEL_WR1:  Data2 = WriteData1;
      SEL_WR0:  Data2 = WriteData0;
      default:  Data2 = regs[Read2];
    endcase
  end

  reg_scoreboard #(.ADDR(ADDR), .ZERO_REG(ZERO_REG)) u_sb (
    .clock       (clock),
    .reset       (reset),
    .reserve     (Reserve),
    .reserve_reg (ReserveReg),
    .wr0_en      (wr0_ok),
    .wr0_reg     (WriteReg0),
    .wr1_en      (wr1_ok),
    .wr1_reg     (WriteReg1),
    .read1       (Read1),
    .read2       (Read2),
    .busy1       (Busy1),
    .busy2       (Busy2)
  );

endmodule
